// File: rtl/seq_trigger_pkg.sv
// seq_trigger_pkg: shared state encoding and defaults for the sequential trigger
package seq_trigger_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_FIRED} state_t;
  localparam int WIDTH_DEF = 8;
endpackage

// File: rtl/seq_trigger_match.sv
// seq_trigger_match: masked pattern compare with optional change-of-value qualifier
module seq_trigger_match #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] data,
  input  logic [WIDTH-1:0] prev,
  input  logic [WIDTH-1:0] pat,
  input  logic [WIDTH-1:0] mask,
  input  logic             edge_en,
  output logic             hit
);
  assign hit = (((data ^ pat) & mask) == '0) && (!edge_en || data != prev);
endmodule

// File: rtl/seq_trigger.sv
// seq_trigger: multi-stage masked-pattern sequence trigger with repeat counts and timeouts
module seq_trigger
  import seq_trigger_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int STAGES = 4,
  parameter int RPT_W  = 4,
  parameter int TMO_W  = 8,
  parameter int FCNT_W = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic [WIDTH-1:0]          in_data,
  input  logic                      cfg_we,
  input  logic [$clog2(STAGES)-1:0] cfg_stage,
  input  logic [WIDTH-1:0]          cfg_pat,
  input  logic [WIDTH-1:0]          cfg_mask,
  input  logic                      cfg_edge,
  input  logic [RPT_W-1:0]          cfg_rpt,
  input  logic [TMO_W-1:0]          cfg_tmo,
  input  logic [$clog2(STAGES)-1:0] cfg_last,
  input  logic                      arm,
  input  logic                      disarm,
  input  logic                      auto_rearm,
  output logic                      triggered,
  output logic                      armed,
  output logic [$clog2(STAGES)-1:0] stage,
  output logic                      cfg_err,
  output logic [WIDTH-1:0]          trig_data,
  output logic [FCNT_W-1:0]         fire_cnt
);
  localparam int SW = $clog2(STAGES);
  state_t state, state_nx;
  logic [WIDTH-1:0] pat_r [STAGES];
  logic [WIDTH-1:0] mask_r [STAGES];
  logic             edge_r [STAGES];
  logic [RPT_W-1:0] rpt_r [STAGES];
  logic [TMO_W-1:0] tmo_r [STAGES];
  logic [SW-1:0]    last_r, last_eff;
  logic [WIDTH-1:0] prev_data;
  logic [RPT_W-1:0] hits, rpt_eff;
  logic [TMO_W-1:0] tmo_cnt;
  logic hit, eval, done, fire, tmo_exp, restart;
  seq_trigger_match #(.WIDTH(WIDTH)) u_match (
    .data(in_data), .prev(prev_data), .pat(pat_r[stage]), .mask(mask_r[stage]),
    .edge_en(edge_r[stage]), .hit(hit)
  );
  always_comb begin
    last_eff = last_r > SW'(STAGES - 1) ? SW'(STAGES - 1) : last_r;
    rpt_eff  = rpt_r[stage] == '0 ? RPT_W'(1) : rpt_r[stage];
    eval     = state == ST_ARMED && in_valid && !arm && !disarm;
    done     = eval && hit && hits + RPT_W'(1) == rpt_eff;
    fire     = done && stage == last_eff;
    tmo_exp  = eval && !done && stage != '0 && tmo_r[stage] != '0 && tmo_cnt + TMO_W'(1) == tmo_r[stage];
    restart  = disarm || arm || (state == ST_FIRED && auto_rearm);
  end
  always_ff @(posedge clk)
    if (rst) state <= ST_IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = disarm ? ST_IDLE :
               arm ? ST_ARMED :
               state == ST_ARMED ? (fire ? ST_FIRED : ST_ARMED) :
               state == ST_FIRED ? (auto_rearm ? ST_ARMED : ST_FIRED) : ST_IDLE;
  end
  always_comb begin
    armed = state == ST_ARMED;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        pat_r[i]  <= '0;
        mask_r[i] <= '0;
        edge_r[i] <= 1'b0;
        rpt_r[i]  <= '0;
        tmo_r[i]  <= '0;
      end
      last_r    <= '0;
      prev_data <= '0;
      stage     <= '0;
      hits      <= '0;
      tmo_cnt   <= '0;
      triggered <= 1'b0;
      cfg_err   <= 1'b0;
      trig_data <= '0;
      fire_cnt  <= '0;
    end else begin
      if (in_valid) prev_data <= in_data;
      cfg_err   <= cfg_we && state != ST_IDLE;
      triggered <= fire;
      if (cfg_we && state == ST_IDLE) begin
        pat_r[cfg_stage]  <= cfg_pat;
        mask_r[cfg_stage] <= cfg_mask;
        edge_r[cfg_stage] <= cfg_edge;
        rpt_r[cfg_stage]  <= cfg_rpt;
        tmo_r[cfg_stage]  <= cfg_tmo;
        last_r            <= cfg_last;
      end
      if (restart || tmo_exp) begin
        stage   <= '0;
        hits    <= '0;
        tmo_cnt <= '0;
      end else if (done) begin
        hits    <= '0;
        tmo_cnt <= '0;
        if (!fire) stage <= stage + SW'(1);
        if (fire) trig_data <= in_data;
        if (fire) fire_cnt <= fire_cnt + FCNT_W'(fire_cnt != '1);
      end else if (eval) begin
        hits    <= hits + RPT_W'(hit);
        tmo_cnt <= tmo_cnt + TMO_W'(stage != '0);
      end
    end
  end
endmodule

// File: tb/tb_seq_trigger.sv
// tb_seq_trigger: directed sequences with a scoreboard checking every trigger pulse
module tb_seq_trigger;
  logic       clk, rst, in_valid, cfg_we, cfg_edge, arm, disarm, auto_rearm;
  logic [7:0] in_data, cfg_pat, cfg_mask, cfg_tmo, trig_data;
  logic [1:0] cfg_stage, cfg_last, stage, fire_cnt;
  logic [3:0] cfg_rpt;
  logic       triggered, armed, cfg_err;
  int total = 0, bad = 0, cyc = 0;
  typedef struct { logic [7:0] d; int fc; int cyc; } exp_t;
  exp_t q[$];
  exp_t e;
  seq_trigger #(.WIDTH(8), .STAGES(4), .RPT_W(4), .TMO_W(8), .FCNT_W(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .cfg_we(cfg_we),
    .cfg_stage(cfg_stage), .cfg_pat(cfg_pat), .cfg_mask(cfg_mask), .cfg_edge(cfg_edge),
    .cfg_rpt(cfg_rpt), .cfg_tmo(cfg_tmo), .cfg_last(cfg_last), .arm(arm), .disarm(disarm),
    .auto_rearm(auto_rearm), .triggered(triggered), .armed(armed), .stage(stage),
    .cfg_err(cfg_err), .trig_data(trig_data), .fire_cnt(fire_cnt)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask
  always @(negedge clk)
    if (!rst && triggered) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_trigger: got trig_data 0x%0h, expected no pulse", trig_data);
      end else begin
        e = q.pop_front();
        chk("trig_cycle", cyc, e.cyc);
        chk("trig_data", trig_data, e.d);
        chk("fire_cnt", fire_cnt, e.fc);
      end
    end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic samp(input logic [7:0] d);
    in_valid = 1;
    in_data = d;
    step();
    in_valid = 0;
  endtask
  task automatic samp_fire(input logic [7:0] d, input int fc);
    samp(d);
    q.push_back('{d, fc, cyc});
  endtask
  task automatic cfg(input logic [1:0] s, input logic [7:0] p, input logic [7:0] m, input logic ed,
                     input logic [3:0] r, input logic [7:0] t, input logic [1:0] l);
    cfg_stage = s; cfg_pat = p; cfg_mask = m; cfg_edge = ed; cfg_rpt = r; cfg_tmo = t; cfg_last = l;
    cfg_we = 1;
    step();
    cfg_we = 0;
  endtask
  task automatic do_arm();
    arm = 1;
    step();
    arm = 0;
  endtask
  task automatic do_disarm();
    disarm = 1;
    step();
    disarm = 0;
  endtask
  initial begin
    rst = 1; in_valid = 1; in_data = 8'hC3; cfg_we = 1; cfg_stage = 2'd3; cfg_pat = 8'hFF;
    cfg_mask = 8'hFF; cfg_edge = 1; cfg_rpt = 4'hF; cfg_tmo = 8'hFF; cfg_last = 2'd3;
    arm = 1; disarm = 0; auto_rearm = 1;
    step(); step();
    chk("rst_triggered", triggered, 0);
    chk("rst_armed", armed, 0);
    chk("rst_stage", stage, 0);
    chk("rst_cfg_err", cfg_err, 0);
    chk("rst_trig_data", trig_data, 0);
    chk("rst_fire_cnt", fire_cnt, 0);
    in_valid = 0; in_data = 0; cfg_we = 0; cfg_stage = 0; cfg_pat = 0; cfg_mask = 0; cfg_edge = 0;
    cfg_rpt = 0; cfg_tmo = 0; cfg_last = 0; arm = 0; auto_rearm = 0;
    step();
    rst = 0;
    step();
    // zeroed config: mask 0, last 0, rpt 0 -> any sample completes
    do_arm();
    chk("armed_after_arm", armed, 1);
    samp_fire(8'h77, 1);
    step();
    rst = 1;
    step();
    rst = 0;
    chk("rst2_fire_cnt", fire_cnt, 0);
    cfg(0, 8'hA5, 8'hFF, 0, 1, 0, 1);
    cfg(1, 8'h3C, 8'hFF, 0, 1, 0, 1);
    do_arm();
    samp(8'h00); chk("s2_stage_00", stage, 0);
    samp(8'hA5); chk("s2_stage_a5", stage, 1);
    samp(8'h11); chk("s2_stage_11", stage, 1);
    samp_fire(8'h3C, 1);
    step();
    chk("s2_fired_not_armed", armed, 0);
    do_disarm();
    cfg(0, 8'h01, 8'h01, 1, 3, 0, 1);
    cfg(1, 8'hFF, 8'hFF, 0, 1, 0, 1);
    do_arm();
    samp(8'h01); chk("re_01", stage, 0);
    samp(8'h01); chk("re_01b", stage, 0);
    samp(8'h03); chk("re_03", stage, 0);
    samp(8'h02); chk("re_02", stage, 0);
    samp(8'h05); chk("re_05_adv", stage, 1);
    samp_fire(8'hFF, 2);
    step();
    do_disarm();
    cfg(0, 8'h10, 8'hFF, 0, 1, 0, 1);
    cfg(1, 8'h20, 8'hFF, 0, 1, 2, 1);
    do_arm();
    samp(8'h10); chk("to_adv", stage, 1);
    samp(8'h00); chk("to_first_miss", stage, 1);
    samp(8'h00); chk("to_expired", stage, 0);
    samp(8'h10); chk("to_adv2", stage, 1);
    in_data = 8'h00;
    step(); step(); step();
    chk("to_novalid_hold", stage, 1);
    samp(8'h00); chk("to_miss2", stage, 1);
    samp_fire(8'h20, 3);
    step();
    arm = 1; disarm = 1;
    step();
    arm = 0; disarm = 0;
    chk("armdisarm_armed", armed, 0);
    cfg(0, 8'h10, 8'hFF, 0, 1, 0, 1);
    chk("idle_cfg_no_err", cfg_err, 0);
    do_arm();
    cfg(0, 8'h99, 8'hFF, 0, 1, 0, 1);
    chk("armed_cfg_err", cfg_err, 1);
    step();
    chk("cfg_err_pulse_end", cfg_err, 0);
    samp(8'h10); chk("cfg_unchanged", stage, 1);
    samp_fire(8'h20, 3);
    auto_rearm = 1;
    chk("fired_state", armed, 0);
    step();
    chk("auto_rearmed", armed, 1);
    chk("auto_stage0", stage, 0);
    samp(8'h10);
    samp_fire(8'h20, 3);
    step();
    samp(8'h10);
    samp_fire(8'h20, 3);
    auto_rearm = 0;
    step(); step(); step();
    chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
